cnn_sched: RTL and testbench

Inference-frame sequencer for the CNN pipeline (conv/max/conv/max/dense/out chain).
- Launches a frame by pulsing strt into stage 0.
- Tracks each stage's completion pulse strictly in order, then waits for the result byte's tx_done.
- Enforces a per-stage watchdog and raises a sticky error plus a one-cycle abort on out-of-order completion or stall.
- Owns the top-level bsy and a frame counter; sits beside the layer chain at core level.

---
 rtl/cnn_sched.sv | 161 ++++++++++++++++
 tb/tb_cnn_sched.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cnn_sched.sv
// Inference-frame sequencer: launches a frame, tracks stage completions in order,
// waits for the result transmit, and traps ordering faults or stalls into a sticky error.
module cnn_sched #(
  parameter int NUM_STG = 6,
  parameter int TMO_W   = 20,
  parameter int TMO_MAX = 1000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               go,
  input  logic [NUM_STG-1:0] stg_done,
  input  logic               tx_done,
  input  logic               err_clr,
  output logic               strt,
  output logic               bsy,
  output logic [2:0]         stg,
  output logic               frm_done,
  output logic               abort,
  output logic               err,
  output logic [7:0]         frm_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_ERR} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_MAX - 1);
  localparam logic [2:0]       STG_LAST  = 3'(NUM_STG - 1);
  localparam logic [2:0]       STG_DRAIN = 3'(NUM_STG);

  state_t             state_q, state_d;
  logic               strt_q, strt_d;
  logic               bsy_q, bsy_d;
  logic [2:0]         stg_q, stg_d;
  logic               frm_done_q, frm_done_d;
  logic               abort_q, abort_d;
  logic               err_q, err_d;
  logic [7:0]         frm_cnt_q, frm_cnt_d;
  logic [TMO_W-1:0]   wdog_q, wdog_d;

  logic [NUM_STG-1:0] want;
  logic               hit;
  logic               any_done;
  logic               tmo;

  // Only the exact one-hot bit of the awaited stage counts as an advance.
  assign want     = NUM_STG'(1) << stg_q;
  assign hit      = (stg_done == want);
  assign any_done = |stg_done;
  assign tmo      = (wdog_q == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      strt_q     <= 1'b0;
      bsy_q      <= 1'b0;
      stg_q      <= 3'd0;
      frm_done_q <= 1'b0;
      abort_q    <= 1'b0;
      err_q      <= 1'b0;
      frm_cnt_q  <= 8'd0;
      wdog_q     <= '0;
    end else begin
      state_q    <= state_d;
      strt_q     <= strt_d;
      bsy_q      <= bsy_d;
      stg_q      <= stg_d;
      frm_done_q <= frm_done_d;
      abort_q    <= abort_d;
      err_q      <= err_d;
      frm_cnt_q  <= frm_cnt_d;
      wdog_q     <= wdog_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    strt_d     = 1'b0;
    bsy_d      = bsy_q;
    stg_d      = stg_q;
    frm_done_d = 1'b0;
    abort_d    = 1'b0;
    err_d      = err_q;
    frm_cnt_d  = frm_cnt_q;
    wdog_d     = wdog_q;

    unique case (state_q)
      S_IDLE: begin
        wdog_d = '0;
        // A go coinciding with the frame-done pulse waits one cycle.
        if (go && !frm_done_q) begin
          state_d = S_RUN;
          strt_d  = 1'b1;
          bsy_d   = 1'b1;
          stg_d   = 3'd0;
        end
      end

      S_RUN: begin
        if (any_done && !hit) begin
          state_d = S_ERR;
          abort_d = 1'b1;
          err_d   = 1'b1;
          wdog_d  = '0;
        end else if (hit) begin
          wdog_d = '0;
          if (stg_q == STG_LAST) begin
            state_d = S_DRAIN;
            stg_d   = STG_DRAIN;
          end else begin
            stg_d = stg_q + 3'd1;
          end
        end else if (tmo) begin
          state_d = S_ERR;
          abort_d = 1'b1;
          err_d   = 1'b1;
          wdog_d  = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_DRAIN: begin
        if (any_done || (!tx_done && tmo)) begin
          state_d = S_ERR;
          abort_d = 1'b1;
          err_d   = 1'b1;
          wdog_d  = '0;
        end else if (tx_done) begin
          state_d    = S_IDLE;
          frm_done_d = 1'b1;
          bsy_d      = 1'b0;
          stg_d      = 3'd0;
          frm_cnt_d  = frm_cnt_q + 8'd1;
          wdog_d     = '0;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      S_ERR: begin
        wdog_d = '0;
        if (err_clr) begin
          state_d = S_IDLE;
          err_d   = 1'b0;
          bsy_d   = 1'b0;
          stg_d   = 3'd0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign strt     = strt_q;
  assign bsy      = bsy_q;
  assign stg      = stg_q;
  assign frm_done = frm_done_q;
  assign abort    = abort_q;
  assign err      = err_q;
  assign frm_cnt  = frm_cnt_q;

endmodule

// File: tb/tb_cnn_sched.sv
// Directed bench for cnn_sched: nominal frames, ordering faults, watchdog, collisions,
// async reset and frame-counter wrap, with a queue of expected frame counts.
module tb_cnn_sched;

  localparam int NUM_STG = 6;
  localparam int TMO_MAX = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         go;
  logic [5:0]   stg_done;
  logic         tx_done;
  logic         err_clr;
  logic         strt, bsy, frm_done, abort, err;
  logic [2:0]   stg;
  logic [7:0]   frm_cnt;

  int           total = 0;
  int           bad = 0;
  int           done_seen = 0;
  logic [7:0]   exp_cnt = 8'd0;
  logic [7:0]   sb[$];

  cnn_sched #(.NUM_STG(NUM_STG), .TMO_W(8), .TMO_MAX(TMO_MAX)) dut (
    .clk(clk), .rst_n(rst_n), .go(go), .stg_done(stg_done), .tx_done(tx_done),
    .err_clr(err_clr), .strt(strt), .bsy(bsy), .stg(stg), .frm_done(frm_done),
    .abort(abort), .err(err), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_strt"}, strt, 0);
    check({tag, "_bsy"}, bsy, 0);
    check({tag, "_stg"}, stg, 0);
    check({tag, "_frm_done"}, frm_done, 0);
    check({tag, "_abort"}, abort, 0);
    check({tag, "_err"}, err, 0);
  endtask

  // Starts in an IDLE cycle; ends one cycle after frm_done (or after error clear).
  task automatic frame(input int gap, input int drain, input bit hold_go,
                       input bit drain_err, input bit collide);
    logic [7:0] e;
    go = 1'b1;
    if (!drain_err) begin
      exp_cnt = exp_cnt + 8'd1;
      sb.push_back(exp_cnt);
    end
    tick();
    if (!hold_go) go = 1'b0;
    check("strt_pulse", strt, 1);
    check("bsy_run", bsy, 1);
    check("stg_first", stg, 0);
    for (int k = 0; k < NUM_STG; k++) begin
      repeat (gap) tick();
      stg_done = 6'b000001 << k;
      tick();
      stg_done = '0;
      check("stg_adv", stg, k + 1);
      check("strt_once", strt, 0);
      check("no_err", err, 0);
    end
    repeat (drain) tick();
    if (drain_err) begin
      stg_done = 6'b000001;
      tick();
      stg_done = '0;
      go = 1'b0;
      check("drain_abort", abort, 1);
      check("drain_err", err, 1);
      check("drain_stg", stg, NUM_STG);
      check("drain_bsy", bsy, 1);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("drain_clr_err", err, 0);
      check("drain_clr_bsy", bsy, 0);
    end else begin
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      go = 1'b0;
      check("frm_done", frm_done, 1);
      check("bsy_done", bsy, 0);
      check("stg_done_idle", stg, 0);
      if (frm_done === 1'b1) done_seen++;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("frm_cnt", frm_cnt, e);
      end else begin
        check("sb_nonempty", 0, 1);
      end
      if (collide) go = 1'b1;
      tick();
      check("frm_done_1cyc", frm_done, 0);
      check("strt_collide", strt, 0);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0; go = 1'b0; stg_done = '0; tx_done = 1'b0; err_clr = 1'b0;
    #12;
    check_idle_outputs("reset");
    check("reset_cnt", frm_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Nominal frame with the pulse schedule 5,10,..,30 and tx_done at 40.
    frame(4, 9, 1'b0, 1'b0, 1'b1);

    // go held across the frm_done cycle is taken one cycle later.
    tick();
    check("strt_after_collide", strt, 1);
    go = 1'b0;
    stg_done = 6'b000010;
    tick();
    stg_done = '0;
    check("ooo_abort", abort, 1);
    check("ooo_err", err, 1);
    check("ooo_stg", stg, 0);
    check("ooo_bsy", bsy, 1);
    tick();
    check("ooo_abort_1cyc", abort, 0);
    check("ooo_err_sticky", err, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check_idle_outputs("ooo_clr");
    check("ooo_cnt_kept", frm_cnt, exp_cnt);

    // Watchdog expiry with no stage activity.
    go = 1'b1;
    tick();
    go = 1'b0;
    check("tmo_strt", strt, 1);
    n = 0;
    while (abort !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    check("tmo_latency", n, TMO_MAX);
    check("tmo_err", err, 1);
    check("tmo_stg", stg, 0);
    tick();
    check("tmo_abort_1cyc", abort, 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("tmo_clr", err, 0);

    // Advance on the last watchdog cycle beats the timeout.
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (TMO_MAX - 1) tick();
    stg_done = 6'b000001;
    tick();
    stg_done = '0;
    check("edge_no_abort", abort, 0);
    check("edge_no_err", err, 0);
    check("edge_stg", stg, 1);
    stg_done = 6'b000001;
    tick();
    stg_done = '0;
    check("repeat_abort", abort, 1);
    check("repeat_stg", stg, 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("repeat_clr", err, 0);

    // go held through an entire frame, then a stage fault during DRAIN.
    frame(1, 2, 1'b1, 1'b0, 1'b0);
    frame(0, 1, 1'b0, 1'b1, 1'b0);

    // go together with err_clr must not launch a frame.
    go = 1'b1;
    tick();
    go = 1'b0;
    stg_done = 6'b000100;
    tick();
    stg_done = '0;
    check("coll_err", err, 1);
    go = 1'b1;
    err_clr = 1'b1;
    tick();
    go = 1'b0;
    err_clr = 1'b0;
    check("coll_err_clr", err, 0);
    check("coll_no_strt", strt, 0);
    check("coll_bsy", bsy, 0);
    tick();
    check("coll_no_strt2", strt, 0);
    check("coll_idle_bsy", bsy, 0);

    // Asynchronous reset in the middle of a frame.
    go = 1'b1;
    tick();
    go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stg_done = 6'b000001 << k;
      tick();
    end
    stg_done = '0;
    check("pre_rst_stg", stg, 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    check("async_rst_cnt", frm_cnt, 0);
    exp_cnt = 8'd0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    frame(4, 9, 1'b0, 1'b0, 1'b0);

    // Counter wrap over 256 frames from a fresh reset.
    rst_n = 1'b0;
    #1;
    check("wrap_rst_cnt", frm_cnt, 0);
    exp_cnt = 8'd0;
    sb.delete();
    done_seen = 0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int f = 0; f < 256; f++) frame(0, 0, 1'b0, 1'b0, 1'b0);
    check("wrap_pulses", done_seen, 256);
    check("wrap_cnt_zero", frm_cnt, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
